// File: rtl/stopwatch_cu_if.sv
// Command and status bundle between the stopwatch control unit and its neighbours.
// STOPWATCH_CU_LAP_EN adds the lap button and lap hold level.
interface stopwatch_cu_if;
    logic       btn_run;
    logic       btn_clear;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       run;
    logic       clear;
    logic [1:0] state;
    logic       cmd_err;
`ifdef STOPWATCH_CU_LAP_EN
    logic       btn_lap;
    logic       lap_hold;
`endif

    modport master (
        output btn_run, btn_clear, rx_data, rx_done,
`ifdef STOPWATCH_CU_LAP_EN
        output btn_lap,
        input  lap_hold,
`endif
        input  run, clear, state, cmd_err
    );

    modport slave (
        input  btn_run, btn_clear, rx_data, rx_done,
`ifdef STOPWATCH_CU_LAP_EN
        input  btn_lap,
        output lap_hold,
`endif
        output run, clear, state, cmd_err
    );
endinterface

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: arbitrates button pulses and UART command bytes into run/clear.
// Optional lap hold is enabled by defining STOPWATCH_CU_LAP_EN.
module stopwatch_cu #(
    parameter logic [7:0] CMD_RUN   = 8'h52,
    parameter logic [7:0] CMD_CLEAR = 8'h43,
    parameter logic [7:0] CMD_STOP  = 8'h53,
    parameter logic [7:0] CMD_LAP   = 8'h4C,
    parameter bit         CASE_FOLD = 1'b1
) (
    input logic           clk,
    input logic           rst,
    stopwatch_cu_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    localparam logic [7:0] FOLD_MASK = CASE_FOLD ? 8'hDF : 8'hFF;
`ifdef STOPWATCH_CU_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    // Bit 5 distinguishes upper/lower case in ASCII letters.
    function automatic logic byte_match(input logic [7:0] data, input logic [7:0] cmd);
        return (data & FOLD_MASK) == (cmd & FOLD_MASK);
    endfunction

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   btn_any, uart_sel;
    logic   is_run, is_clear, is_stop, is_lap, lap_known;
`ifdef STOPWATCH_CU_LAP_EN
    logic   lap_q, lap_d;
`endif

    always_comb begin
        is_run    = byte_match(bus.rx_data, CMD_RUN);
        is_clear  = byte_match(bus.rx_data, CMD_CLEAR);
        is_stop   = byte_match(bus.rx_data, CMD_STOP);
        is_lap    = byte_match(bus.rx_data, CMD_LAP);
        lap_known = LAP_ON && is_lap;
`ifdef STOPWATCH_CU_LAP_EN
        btn_any   = bus.btn_run | bus.btn_clear | bus.btn_lap;
`else
        btn_any   = bus.btn_run | bus.btn_clear;
`endif
        // Any button pulse wins the cycle; a simultaneous byte is silently dropped.
        uart_sel  = bus.rx_done && !btn_any;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
`ifdef STOPWATCH_CU_LAP_EN
        lap_d   = lap_q;
`endif
        case (state_q)
            ST_STOP: begin
                if (bus.btn_run) begin
                    state_d = ST_RUN;
                end else if (bus.btn_clear) begin
                    state_d = ST_CLEAR;
                end else if (uart_sel) begin
                    if (is_run) begin
                        state_d = ST_RUN;
                    end else if (is_clear) begin
                        state_d = ST_CLEAR;
                    end else if (!is_stop && !lap_known) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.btn_run || (uart_sel && (is_run || is_stop))) begin
                    state_d = ST_STOP;
`ifdef STOPWATCH_CU_LAP_EN
                    lap_d   = 1'b0;
                end else if (bus.btn_lap && !bus.btn_clear) begin
                    lap_d   = ~lap_q;
                end else if (uart_sel && is_lap) begin
                    lap_d   = ~lap_q;
`endif
                end else if (uart_sel && !is_clear && !lap_known) begin
                    err_d = 1'b1;
                end
            end
            // CLEAR lasts a single cycle and drops everything that arrives meanwhile.
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef STOPWATCH_CU_LAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign bus.lap_hold = lap_q;
`endif

    assign bus.run     = (state_q == ST_RUN);
    assign bus.clear   = (state_q == ST_CLEAR);
    assign bus.state   = state_q;
    assign bus.cmd_err = err_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu: button/UART commands, arbitration, unknown bytes, async reset.
// Lap checks are built when STOPWATCH_CU_LAP_EN is defined.
module tb_stopwatch_cu;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stopwatch_cu_if bus ();

    stopwatch_cu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.btn_run   = 1'b0;
        bus.btn_clear = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
`ifdef STOPWATCH_CU_LAP_EN
        bus.btn_lap   = 1'b0;
`endif

        // Reset held for 3 cycles, then idle.
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_state", {6'd0, bus.state}, 8'h00);
        chk("rst_run", {7'd0, bus.run}, 8'h00);
        chk("rst_clear", {7'd0, bus.clear}, 8'h00);
        chk("rst_err", {7'd0, bus.cmd_err}, 8'h00);

        // Button run/stop toggle.
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("btn_run_on", {7'd0, bus.run}, 8'h01);
        chk("btn_run_state", {6'd0, bus.state}, 8'h01);
        repeat (10) tick();
        chk("run_holds", {7'd0, bus.run}, 8'h01);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("btn_stop_run", {7'd0, bus.run}, 8'h00);
        chk("btn_stop_state", {6'd0, bus.state}, 8'h00);

        // UART clear ignored in RUN, stop by 'S', lowercase clear from STOP.
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        send_byte(8'h43);
        chk("C_in_run_run", {7'd0, bus.run}, 8'h01);
        chk("C_in_run_err", {7'd0, bus.cmd_err}, 8'h00);
        chk("C_in_run_clear", {7'd0, bus.clear}, 8'h00);
        send_byte(8'h53);
        chk("S_stop_state", {6'd0, bus.state}, 8'h00);
        send_byte(8'h63);
        chk("c_clear_on", {7'd0, bus.clear}, 8'h01);
        chk("c_clear_state", {6'd0, bus.state}, 8'h02);
        tick();
        chk("c_clear_off", {7'd0, bus.clear}, 8'h00);
        chk("c_back_stop", {6'd0, bus.state}, 8'h00);

        // Lowercase run/stop via UART.
        send_byte(8'h72);
        chk("r_run", {6'd0, bus.state}, 8'h01);
        send_byte(8'h73);
        chk("s_stop", {6'd0, bus.state}, 8'h00);
        send_byte(8'h53);
        chk("S_in_stop_noop", {6'd0, bus.state}, 8'h00);
        chk("S_in_stop_err", {7'd0, bus.cmd_err}, 8'h00);

        // btn_clear beats a simultaneous 'R'.
        bus.btn_clear = 1'b1;
        bus.rx_data   = 8'h52;
        bus.rx_done   = 1'b1;
        tick();
        bus.btn_clear = 1'b0;
        bus.rx_done   = 1'b0;
        bus.rx_data   = 8'h00;
        chk("arb_clr_state", {6'd0, bus.state}, 8'h02);
        chk("arb_clr_run", {7'd0, bus.run}, 8'h00);
        chk("arb_clr_err", {7'd0, bus.cmd_err}, 8'h00);
        tick();
        chk("arb_clr_back", {6'd0, bus.state}, 8'h00);
        chk("arb_clr_run2", {7'd0, bus.run}, 8'h00);

        // btn_run beats btn_clear.
        bus.btn_run   = 1'b1;
        bus.btn_clear = 1'b1;
        tick();
        bus.btn_run   = 1'b0;
        bus.btn_clear = 1'b0;
        chk("arb_run_state", {6'd0, bus.state}, 8'h01);
        chk("arb_run_clear", {7'd0, bus.clear}, 8'h00);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("arb_run_stop", {6'd0, bus.state}, 8'h00);

        // Unknown byte in STOP and in RUN.
        send_byte(8'h58);
        chk("X_err_on", {7'd0, bus.cmd_err}, 8'h01);
        chk("X_state", {6'd0, bus.state}, 8'h00);
        tick();
        chk("X_err_off", {7'd0, bus.cmd_err}, 8'h00);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        send_byte(8'h58);
        chk("X_run_err", {7'd0, bus.cmd_err}, 8'h01);
        chk("X_run_state", {6'd0, bus.state}, 8'h01);

        // Asynchronous reset mid-RUN, between clock edges.
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_run", {7'd0, bus.run}, 8'h00);
        chk("async_rst_state", {6'd0, bus.state}, 8'h00);
        chk("async_rst_err", {7'd0, bus.cmd_err}, 8'h00);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_state", {6'd0, bus.state}, 8'h00);

`ifdef STOPWATCH_CU_LAP_EN
        send_byte(8'h4C);
        chk("L_stop_lap", {7'd0, bus.lap_hold}, 8'h00);
        chk("L_stop_err", {7'd0, bus.cmd_err}, 8'h00);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        send_byte(8'h4C);
        chk("L_lap_on", {7'd0, bus.lap_hold}, 8'h01);
        chk("L_still_run", {7'd0, bus.run}, 8'h01);
        bus.btn_lap = 1'b1;
        tick();
        bus.btn_lap = 1'b0;
        chk("btn_lap_off", {7'd0, bus.lap_hold}, 8'h00);
        send_byte(8'h6C);
        chk("l_lap_on", {7'd0, bus.lap_hold}, 8'h01);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("stop_lap_clr", {7'd0, bus.lap_hold}, 8'h00);
        chk("stop_lap_state", {6'd0, bus.state}, 8'h00);
`else
        send_byte(8'h4C);
        chk("L_unknown_err", {7'd0, bus.cmd_err}, 8'h01);
        chk("L_unknown_state", {6'd0, bus.state}, 8'h00);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
